// File: rtl/ps2_rx_deserialiser_if.sv
// ps2_rx_deserialiser_if
//  Bundles the PS/2 receive-side signals for ps2_rx_deserialiser.
//  slave  : the deserialiser (consumes the PS/2 lines, produces bytes).
//  master : the environment (transceiver front end plus mouse master SM).
//  Optional feature macro: PS2_RX_ERR_COUNT_EN adds the ERR_COUNT signal.
//
//  Handshake: BYTE_READY is a one-cycle valid strobe with no back-pressure
//  (there is no ready input). BYTE_READ and BYTE_ERROR_CODE change only in
//  the cycle BYTE_READY is high and then hold until the next strobe, so the
//  consumer may capture them in the strobe cycle or any later cycle.
//  STATE_DBG mirrors the receive FSM state for observation only.
interface ps2_rx_deserialiser_if;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic [2:0] STATE_DBG;
`ifdef PS2_RX_ERR_COUNT_EN
    logic [7:0] ERR_COUNT;

    modport slave (
        input  CLK_MOUSE_IN,
        input  DATA_MOUSE_IN,
        input  READ_ENABLE,
        output BYTE_READ,
        output BYTE_ERROR_CODE,
        output BYTE_READY,
        output STATE_DBG,
        output ERR_COUNT
    );

    modport master (
        output CLK_MOUSE_IN,
        output DATA_MOUSE_IN,
        output READ_ENABLE,
        input  BYTE_READ,
        input  BYTE_ERROR_CODE,
        input  BYTE_READY,
        input  STATE_DBG,
        input  ERR_COUNT
    );
`else
    modport slave (
        input  CLK_MOUSE_IN,
        input  DATA_MOUSE_IN,
        input  READ_ENABLE,
        output BYTE_READ,
        output BYTE_ERROR_CODE,
        output BYTE_READY,
        output STATE_DBG
    );

    modport master (
        output CLK_MOUSE_IN,
        output DATA_MOUSE_IN,
        output READ_ENABLE,
        input  BYTE_READ,
        input  BYTE_ERROR_CODE,
        input  BYTE_READY,
        input  STATE_DBG
    );
`endif
endinterface

// File: rtl/ps2_rx_deserialiser.sv
// ps2_rx_deserialiser
//  Receive-only PS/2 device-to-host frame deserialiser. Detects falling edges
//  of the (already filtered) PS/2 clock, shifts in start, 8 data bits (LSB
//  first), odd parity and stop, then strobes BYTE_READY for one cycle with
//  the byte and a 2-bit error code {stop error, parity error}.
//  A mid-frame stall longer than TIMEOUT_CYCLES-1 system clocks discards the
//  partial frame silently.
//  Optional feature macro: PS2_RX_ERR_COUNT_EN enables the saturating
//  ERR_COUNT error-frame counter (parity/stop errors and timeout aborts).
module ps2_rx_deserialiser #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TMO_W          = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    ps2_rx_deserialiser_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Registered state
    logic             clk_q,    clk_d;
    logic [2:0]       state_q,  state_d;
    logic [7:0]       shift_q,  shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic             perr_q,   perr_d;
    logic [7:0]       byte_q,   byte_d;
    logic [1:0]       code_q,   code_d;
    logic             ready_q,  ready_d;
`ifdef PS2_RX_ERR_COUNT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif

    // Decoded helpers
    logic fall;
    logic in_frame;
    logic tmo_hit;

    // Edge detect, frame-active decode and stall detection
    always_comb begin
        clk_d    = bus.CLK_MOUSE_IN;
        fall     = clk_q & ~bus.CLK_MOUSE_IN;
        in_frame = (state_q == ST_DATA) || (state_q == ST_PARITY) ||
                   (state_q == ST_STOP);
        // A falling edge in the same cycle counts as progress, not a stall.
        tmo_hit  = in_frame && !fall && (tmo_q == TMO_LAST);
    end

    // Receive FSM: bit sampling, parity/stop checks, output load and abort
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        perr_d   = perr_q;
        byte_d   = byte_q;
        code_d   = code_q;
        ready_d  = 1'b0;
        tmo_d    = '0;

        // Stall counter only runs while a frame is in flight.
        if (in_frame && !tmo_hit) begin
            tmo_d = fall ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // READ_ENABLE only gates acceptance of a new start bit.
                if (fall && bus.READ_ENABLE && !bus.DATA_MOUSE_IN) begin
                    state_d  = ST_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (fall) begin
                    // LSB arrives first, so shift towards bit 0.
                    shift_d  = {bus.DATA_MOUSE_IN, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (fall) begin
                    // Odd parity: data plus parity bit must hold an odd count of ones.
                    perr_d  = ~(^{shift_q, bus.DATA_MOUSE_IN});
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (fall) begin
                    // Load outputs now so they and the strobe appear together in DONE.
                    byte_d  = shift_q;
                    code_d  = {~bus.DATA_MOUSE_IN, perr_q};
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // One-cycle strobe state; any edge seen here cannot be a valid start bit.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef PS2_RX_ERR_COUNT_EN
    // Saturating count of errored deliveries and timeout aborts
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (((ready_d && (code_d != 2'b00)) || tmo_hit) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.ERR_COUNT = err_cnt_q;
`endif

    // State and datapath registers; reset drops any partial frame
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_q    <= 1'b0;
            state_q  <= ST_IDLE;
            shift_q  <= 8'h00;
            bitcnt_q <= 3'd0;
            tmo_q    <= '0;
            perr_q   <= 1'b0;
            byte_q   <= 8'h00;
            code_q   <= 2'b00;
            ready_q  <= 1'b0;
        end else begin
            clk_q    <= clk_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            tmo_q    <= tmo_d;
            perr_q   <= perr_d;
            byte_q   <= byte_d;
            code_q   <= code_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.BYTE_READ       = byte_q;
    assign bus.BYTE_ERROR_CODE = code_q;
    assign bus.BYTE_READY      = ready_q;
    assign bus.STATE_DBG       = state_q;

endmodule

// File: tb/tb_ps2_rx_deserialiser.sv
// tb_ps2_rx_deserialiser
//  Drives PS/2 frames (directed and random) into ps2_rx_deserialiser and
//  compares every delivered byte against a frame-level reference model.
//  Optional feature macro: PS2_RX_ERR_COUNT_EN also checks ERR_COUNT.
module tb_ps2_rx_deserialiser;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ps2_rx_deserialiser_if bus ();

    ps2_rx_deserialiser dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // ---------------- check / bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: {err_code[1:0], byte[7:0]} per expected delivery
    logic [9:0] exp_q[$];
    logic [9:0] last_exp   = 10'h000;
    int         exp_strobe = 0;
    int         got_strobe = 0;
    int         err_model  = 0;
    int         fall_cyc   = 0;

    // Reference model: build an 11-bit frame (bit 0 = start) from a byte and fault flags
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par,
                                               input logic bad_stop);
        logic p;
        p = (($countones(d) % 2) == 0);
        if (bad_par) p = ~p;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    // Reference model: what the receiver must report for a complete frame
    function automatic logic [9:0] expect_of(input logic [10:0] f);
        logic perr;
        logic serr;
        perr = (($countones(f[9:1]) % 2) == 0);
        serr = (f[10] == 1'b0);
        return {serr, perr, f[8:1]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic push_expect(input logic [10:0] f);
        logic [9:0] e;
        e = expect_of(f);
        exp_q.push_back(e);
        exp_strobe++;
        last_exp = e;
        if (e[9:8] != 2'b00) err_model = sat_inc(err_model);
    endtask

    // Monitor: every strobe is matched against the scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        if (bus.BYTE_READY === 1'b1) begin
            got_strobe++;
            check("ready_latency", cyc - fall_cyc, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("byte_read", {24'h0, bus.BYTE_READ}, {24'h0, e[7:0]});
                check("err_code", {30'h0, bus.BYTE_ERROR_CODE}, {30'h0, e[9:8]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input int half);
        bus.DATA_MOUSE_IN = b;
        repeat (half) @(negedge clk);
        bus.CLK_MOUSE_IN = 1'b0;
        fall_cyc = cyc;
        repeat (half) @(negedge clk);
        bus.CLK_MOUSE_IN = 1'b1;
    endtask

    // Send the first nbits of frame f; expect a delivery only if told to
    task automatic send_frame(input logic [10:0] f, input int half, input int nbits,
                              input bit expect_it, input bit drop_re);
        for (int i = 0; i < nbits; i++) begin
            if (i == 10 && expect_it) push_expect(f);
            send_bit(f[i], half);
            if (i == 0 && drop_re) bus.READ_ENABLE = 1'b0;
        end
        bus.DATA_MOUSE_IN = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        last_exp  = 10'h000;
        err_model = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        repeat (6) @(negedge clk);
        check({tag, "_strobes"}, got_strobe, exp_strobe);
        check({tag, "_hold_byte"}, {24'h0, bus.BYTE_READ}, {24'h0, last_exp[7:0]});
        check({tag, "_hold_code"}, {30'h0, bus.BYTE_ERROR_CODE}, {30'h0, last_exp[9:8]});
        check({tag, "_ready_low"}, {31'h0, bus.BYTE_READY}, 32'h0);
`ifdef PS2_RX_ERR_COUNT_EN
        check({tag, "_err_count"}, {24'h0, bus.ERR_COUNT}, err_model);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        int          half;
        bit          re_off;

        bus.CLK_MOUSE_IN  = 1'b1;
        bus.DATA_MOUSE_IN = 1'b1;
        bus.READ_ENABLE   = 1'b1;
        rst               = 1'b1;
        #1;
        check("rst_async_byte", {24'h0, bus.BYTE_READ}, 32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check_state("reset");

        // 1: clean 0xFA
        send_frame(make_frame(8'hFA, 1'b0, 1'b0), 8, 11, 1'b1, 1'b0);
        check_state("t1_fa");

        // 2: 0xFA with wrong parity bit
        send_frame(make_frame(8'hFA, 1'b1, 1'b0), 6, 11, 1'b1, 1'b0);
        check_state("t2_perr");

        // 3: 0x08 with stop bit 0
        send_frame(make_frame(8'h08, 1'b0, 1'b1), 5, 11, 1'b1, 1'b0);
        check_state("t3_serr");

        // 4: truncated frame times out, then a clean 0x08
        send_frame(make_frame(8'h08, 1'b0, 1'b0), 5, 5, 1'b0, 1'b0);
        repeat (60000) @(negedge clk);
        err_model = sat_inc(err_model);
        check_state("t4_abort");
        send_frame(make_frame(8'h08, 1'b0, 1'b0), 4, 11, 1'b1, 1'b0);
        check_state("t4_after");

        // 5: frames ignored while READ_ENABLE is low; drop mid-frame still delivers
        do_reset();
        bus.READ_ENABLE = 1'b0;
        send_frame(make_frame(8'hAA, 1'b0, 1'b0), 4, 11, 1'b0, 1'b0);
        check_state("t5_disabled");
        bus.READ_ENABLE = 1'b1;
        send_frame(make_frame(8'h55, 1'b0, 1'b0), 4, 11, 1'b1, 1'b1);
        check_state("t5_drop");
        bus.READ_ENABLE = 1'b1;

        // 6: async reset mid-frame, then clean 0xF4
        send_frame(make_frame(8'hF4, 1'b0, 1'b0), 4, 6, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_byte", {24'h0, bus.BYTE_READ}, 32'h0);
        check("t6_async_code", {30'h0, bus.BYTE_ERROR_CODE}, 32'h0);
        exp_q.delete();
        last_exp  = 10'h000;
        err_model = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_state("t6_reset");
        send_frame(make_frame(8'hF4, 1'b0, 1'b0), 4, 11, 1'b1, 1'b0);
        check_state("t6_f4");

        // Random frames: random byte, faults, bit timing, and disabled frames
        for (int n = 0; n < 40; n++) begin
            d      = 8'($urandom_range(0, 255));
            half   = $urandom_range(2, 12);
            re_off = ($urandom_range(0, 5) == 0);
            f      = make_frame(d, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            bus.READ_ENABLE = !re_off;
            send_frame(f, half, 11, !re_off, 1'b0);
            bus.READ_ENABLE = 1'b1;
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        check_state("random");

        check("pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
